// File: rtl/soc_misc_wb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : soc_misc_wb                                                |
// | Description : Misc Wishbone slave with a keyed warmboot register,        |
// |               N_CH LED blink generators sharing one prescaler and an     |
// |               optional watchdog reset request.                           |
// | Options     : define SOC_MISC_WDT_EN to build the watchdog.              |
// | Revision    : 1.0  initial multi-channel release                         |
// +--------------------------------------------------------------------------+
module soc_misc_wb #(
  parameter int N_CH    = 2,
  parameter int TW      = 11,
  parameter int PRESC_W = 14,
  parameter int WDT_W   = 24,
  parameter int AW      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   wb_addr,
  output logic [31:0]     wb_rdata,
  input  logic [31:0]     wb_wdata,
  input  logic            wb_we,
  input  logic            wb_cyc,
  output logic            wb_ack,
  output logic            boot_now,
  output logic [1:0]      boot_sel,
  output logic [N_CH-1:0] led,
  output logic            rst_req
);

  localparam logic [15:0] ID_MAGIC   = 16'h4D53;
  localparam logic [3:0]  N_CH_FIELD = 4'(N_CH);
  localparam logic [7:0]  BOOT_KEY   = 8'hA5;
`ifdef SOC_MISC_WDT_EN
  localparam logic        WDT_PRESENT = 1'b1;
`else
  localparam logic        WDT_PRESENT = 1'b0;
`endif

  typedef enum logic {
    ST_ON  = 1'b0,
    ST_OFF = 1'b1
  } blink_state_e;

  // Bus, boot and prescaler state
  logic               ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               boot_now_q, boot_now_d;
  logic [1:0]         boot_sel_q, boot_sel_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q, tick_d;

  logic [31:0]        addr_w;
  logic               wr_commit;
  logic [31:0]        rd_mux;
  logic [31:0]        wdt_rd;
  logic [N_CH-1:0]    led_sel;
  logic [31:0]        led_rd [N_CH];
  logic               unused_wdata;

  assign addr_w       = 32'(wb_addr);
  // Writes take effect at the end of the ack cycle, while the master still holds cyc.
  assign wr_commit    = wb_cyc & wb_we & ack_q;
  assign unused_wdata = ^wb_wdata;

  assign wb_ack   = ack_q;
  assign wb_rdata = rdata_q;
  assign boot_now = boot_now_q;
  assign boot_sel = boot_sel_q;

  // Read mux: selects the addressed register word, zero for unmapped words
  always_comb begin
    rd_mux = '0;
    if (addr_w == 32'd0) begin
      rd_mux = {29'b0, boot_now_q, boot_sel_q};
    end else if (addr_w == 32'd1) begin
      rd_mux = {ID_MAGIC, 7'b0, WDT_PRESENT, 4'b0, N_CH_FIELD};
    end else if (addr_w == 32'd2) begin
      rd_mux = wdt_rd;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (led_sel[c]) rd_mux = led_rd[c];
      end
    end
  end

  // Next state for ack/rdata, the keyed boot register and the prescaler
  always_comb begin
    ack_d      = wb_cyc & ~ack_q;
    rdata_d    = (wb_cyc & ~ack_q) ? rd_mux : 32'h0;
    boot_now_d = boot_now_q;
    boot_sel_d = boot_sel_q;
    // Once boot_now is set the register is frozen until reset.
    if (wr_commit && (addr_w == 32'd0) && (wb_wdata[15:8] == BOOT_KEY) && !boot_now_q) begin
      boot_now_d = wb_wdata[2];
      boot_sel_d = wb_wdata[1:0];
    end
    presc_d = presc_q + PRESC_W'(1);
    // Registered so the tick lands in the cycle the counter reads zero.
    tick_d  = &presc_q;
  end

  // Bus, boot and prescaler registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      boot_now_q <= 1'b0;
      boot_sel_q <= '0;
      presc_q    <= '0;
      tick_q     <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      boot_now_q <= boot_now_d;
      boot_sel_q <= boot_sel_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic               ena_q, ena_d;
    logic [TW-1:0]      on_q, on_d;
    logic [TW-1:0]      off_q, off_d;
    logic [TW-1:0]      cnt_q, cnt_d;
    blink_state_e       state_q, state_d;
    logic               led_q, led_d;
    logic               ch_wr;
    logic [TW-1:0]      limit;
    logic [31:0]        rd_word;

    assign led_sel[c] = (addr_w == 32'(8 + c));
    assign ch_wr      = wr_commit & led_sel[c];
    assign led[c]     = led_q;
    assign led_rd[c]  = rd_word;

    // Register read-back layout: ena at 31, off at 16, on at 0
    always_comb begin
      rd_word            = '0;
      rd_word[31]        = ena_q;
      rd_word[16 +: TW]  = off_q;
      rd_word[0 +: TW]   = on_q;
    end

    // Blink FSM: a config write restarts in ON and outranks a coincident tick
    always_comb begin
      ena_d   = ena_q;
      on_d    = on_q;
      off_d   = off_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      limit   = (state_q == ST_ON) ? on_q : off_q;
      if (ch_wr) begin
        ena_d   = wb_wdata[31];
        on_d    = wb_wdata[0 +: TW];
        off_d   = wb_wdata[16 +: TW];
        state_d = ST_ON;
        cnt_d   = '0;
      end else if (!ena_q) begin
        state_d = ST_ON;
        cnt_d   = '0;
      end else if (tick_q) begin
        if (cnt_q == limit) begin
          state_d = (state_q == ST_ON) ? ST_OFF : ST_ON;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + TW'(1);
        end
      end
      led_d = ena_q & (state_q == ST_ON);
    end

    // Channel configuration, FSM state and registered LED output
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ena_q   <= 1'b0;
        on_q    <= '0;
        off_q   <= '0;
        cnt_q   <= '0;
        state_q <= ST_ON;
        led_q   <= 1'b0;
      end else begin
        ena_q   <= ena_d;
        on_q    <= on_d;
        off_q   <= off_d;
        cnt_q   <= cnt_d;
        state_q <= state_d;
        led_q   <= led_d;
      end
    end
  end

`ifdef SOC_MISC_WDT_EN
  logic             wdt_ena_q, wdt_ena_d;
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             wdt_wr;
  logic             wdt_fire;

  assign wdt_wr  = wr_commit & (addr_w == 32'd2);
  assign rst_req = wdt_fire;
  assign wdt_rd  = {wdt_ena_q, 7'b0, 24'(wdt_cnt_q)};

  // Watchdog countdown; a kick landing in the expiry cycle suppresses the request
  always_comb begin
    wdt_ena_d = wdt_ena_q;
    wdt_cnt_d = wdt_cnt_q;
    wdt_fire  = 1'b0;
    if (wdt_wr) begin
      wdt_ena_d = wb_wdata[31];
      wdt_cnt_d = wb_wdata[WDT_W-1:0];
    end else if (wdt_ena_q) begin
      if (wdt_cnt_q == '0) begin
        wdt_fire  = 1'b1;
        wdt_ena_d = 1'b0;
      end else begin
        wdt_cnt_d = wdt_cnt_q - WDT_W'(1);
      end
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_ena_q <= 1'b0;
      wdt_cnt_q <= '0;
    end else begin
      wdt_ena_q <= wdt_ena_d;
      wdt_cnt_q <= wdt_cnt_d;
    end
  end
`else
  assign rst_req = 1'b0;
  assign wdt_rd  = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_soc_misc_wb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_soc_misc_wb                                             |
// | Description : Directed self-checking bench for soc_misc_wb               |
// |               (fast prescaler, PRESC_W=2). Honours SOC_MISC_WDT_EN.      |
// | Revision    : 1.0  initial                                               |
// +--------------------------------------------------------------------------+
module tb_soc_misc_wb;

  localparam int N_CH = 2;
`ifdef SOC_MISC_WDT_EN
  localparam logic [31:0] ID_EXP = 32'h4D53_0102;
`else
  localparam logic [31:0] ID_EXP = 32'h4D53_0002;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      wb_addr = '0;
  logic [31:0]     wb_wdata = '0;
  logic [31:0]     wb_rdata;
  logic            wb_we = 1'b0;
  logic            wb_cyc = 1'b0;
  logic            wb_ack;
  logic            boot_now;
  logic [1:0]      boot_sel;
  logic [N_CH-1:0] led;
  logic            rst_req;

  int n_checks = 0;
  int n_errors = 0;
  int rst_req_cnt = 0;
  int led1_hi = 0;

  always #5 clk = ~clk;

  soc_misc_wb #(
    .N_CH(N_CH), .TW(11), .PRESC_W(2), .WDT_W(24), .AW(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_addr(wb_addr), .wb_rdata(wb_rdata), .wb_wdata(wb_wdata),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
    .boot_now(boot_now), .boot_sel(boot_sel), .led(led), .rst_req(rst_req)
  );

  always @(negedge clk) begin
    if (rst_req) rst_req_cnt++;
    if (led[1])  led1_hi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic [3:0] a, input logic we, input logic [31:0] d,
                         output logic [31:0] rd);
    @(negedge clk);
    wb_cyc = 1'b1; wb_we = we; wb_addr = a; wb_wdata = d;
    @(negedge clk);
    rd = wb_rdata;
    @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(a, 1'b1, d, dummy);
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] rd);
    wb_xfer(a, 1'b0, 32'h0, rd);
  endtask

  task automatic wait_led0(input logic lvl);
    for (int i = 0; i < 100 && led[0] !== lvl; i++) @(negedge clk);
    check("wait_led0", 32'(led[0]), 32'(lvl));
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (led[0] === lvl && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int n;

    repeat (3) @(negedge clk);
    check("rst_outs", {25'b0, wb_ack, boot_now, boot_sel, led, rst_req}, 32'h0);
    check("rst_rdata", wb_rdata, 32'h0);
    rst_n = 1'b1;

    wb_read(4'd1, rd);
    check("id", rd, ID_EXP);

    // Keyed boot register
    wb_write(4'd0, 32'h0000_5A07);
    check("boot_badkey", {29'b0, boot_now, boot_sel}, 32'h0);
    wb_write(4'd0, 32'h0000_A506);
    check("boot_set", {29'b0, boot_now, boot_sel}, 32'h6);
    wb_read(4'd0, rd);
    check("boot_rd", rd, 32'h6);
    wb_write(4'd0, 32'h0000_A501);
    check("boot_locked", {29'b0, boot_now, boot_sel}, 32'h6);
    wb_write(4'd0, 32'h0000_5A01);
    check("boot_locked_badkey", {29'b0, boot_now, boot_sel}, 32'h6);

    // LED register read-back and unmapped word
    wb_write(4'd9, 32'h7FFF_FFFF);
    wb_read(4'd9, rd);
    check("led1_rd", rd, 32'h07FF_07FF);
    wb_write(4'd10, 32'hFFFF_FFFF);
    wb_read(4'd10, rd);
    check("unmapped_rd", rd, 32'h0);

    // Blink timing: on=1 -> 2 ticks (8 clk), off=2 -> 3 ticks (12 clk)
    led1_hi = 0;
    wb_write(4'd8, 32'h8002_0001);
    wb_read(4'd8, rd);
    check("led0_rd", rd, 32'h8002_0001);
    wait_led0(1'b0);
    wait_led0(1'b1);
    run_len(1'b1, n); check("on_len", 32'(n), 32'd8);
    run_len(1'b0, n); check("off_len", 32'(n), 32'd12);
    run_len(1'b1, n); check("on_len2", 32'(n), 32'd8);

    // Rewrite mid-OFF restarts the period in ON
    repeat (4) @(negedge clk);
    wb_write(4'd8, 32'h8002_0001);
    check("rewrite_pre", 32'(led[0]), 32'd0);
    @(negedge clk);
    check("rewrite_hi", 32'(led[0]), 32'd1);
    repeat (3) @(negedge clk);
    check("rewrite_hold", 32'(led[0]), 32'd1);
    check("led1_quiet", 32'(led1_hi), 32'd0);

`ifdef SOC_MISC_WDT_EN
    rst_req_cnt = 0;
    wb_write(4'd2, 32'h8000_0003);
    repeat (2) @(negedge clk);
    check("wdt_pre", 32'(rst_req), 32'd0);
    @(negedge clk);
    check("wdt_fire", 32'(rst_req), 32'd1);
    @(negedge clk);
    check("wdt_once", 32'(rst_req), 32'd0);
    repeat (10) @(negedge clk);
    check("wdt_pulses", 32'(rst_req_cnt), 32'd1);
    wb_read(4'd2, rd);
    check("wdt_rd_expired", rd, 32'h0);
    rst_req_cnt = 0;
    repeat (10) wb_write(4'd2, 32'h8000_0003);
    wb_write(4'd2, 32'h0000_0000);
    repeat (8) @(negedge clk);
    check("wdt_kick", 32'(rst_req_cnt), 32'd0);
    wb_read(4'd2, rd);
    check("wdt_rd_off", rd, 32'h0);
`else
    rst_req_cnt = 0;
    wb_write(4'd2, 32'h8000_0003);
    wb_read(4'd2, rd);
    check("wdt_absent_rd", rd, 32'h0);
    repeat (10) @(negedge clk);
    check("wdt_absent_req", 32'(rst_req_cnt), 32'd0);
`endif

    // Back-to-back cycle: ack alternates, rdata only valid with ack
    @(negedge clk);
    wb_addr = 4'd1; wb_we = 1'b0; wb_cyc = 1'b1;
    check("b2b_ack0", 32'(wb_ack), 32'd0);
    @(negedge clk);
    check("b2b_ack1", 32'(wb_ack), 32'd1);
    check("b2b_rdata1", wb_rdata, ID_EXP);
    @(negedge clk);
    check("b2b_ack2", 32'(wb_ack), 32'd0);
    check("b2b_rdata2", wb_rdata, 32'h0);
    @(negedge clk);
    check("b2b_ack3", 32'(wb_ack), 32'd1);
    wb_cyc = 1'b0;
    @(negedge clk);
    check("b2b_idle", 32'(wb_ack), 32'd0);
    wb_read(4'd5, rd);
    check("rd_addr5", rd, 32'h0);

    // Asynchronous reset while the LED is lit
    wait_led0(1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'd0);
    check("async_rst_boot", {29'b0, boot_now, boot_sel}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_led", 32'(led), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
